borrow_look_ahead_subtractor: RTL and testbench
===============================================

# borrow_look_ahead_subtractor

Multi-cycle unsigned/two's-complement subtractor computing D = a − b − borrow_in for WIDTH-bit operands, one 8-bit borrow-look-ahead slice per clock, least-significant slice first. The inter-slice borrow is held in a flop. It is the subtract-direction companion to the team's 8-bit carry look-ahead adder and is used where wide subtraction must run at the narrow-slice clock rate. A start/busy/done handshake connects it to a controlling FSM.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of 8, minimum 8. NSLICE = WIDTH/8 is derived.
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  minuend; sampled on the accepting edge.
- b  input  WIDTH  subtrahend; sampled on the accepting edge.
- borrow_in  input  1  initial borrow; sampled on the accepting edge.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- D  output  WIDTH  difference; held until the next completion.
- borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned).
- V  output  1  signed overflow; present only with OVERFLOW_FLAG_EN.

## Operation
- Two states:
  - IDLE → RUN on a clock edge where start=1 and busy=0. That edge latches a, b and borrow_in, sets slice index k=0 and clears the partial-result register.
  - RUN → IDLE on the edge that computes slice NSLICE−1.
- Per slice, with x=a[8k+7:8k] and y=b[8k+7:8k]:
  - generate g = ~x & y; propagate p = ~(x ^ y).
  - borrows: c0 = held borrow; c(i+1) = g(i) | p(i)&c(i), fully expanded look-ahead (no ripple through i).
  - difference bits d(i) = x(i) ^ y(i) ^ c(i).
  - c8 is stored as the held borrow for the next slice.
- Final edge: D ← full partial result; borrow_out ← c8 of the last slice; done=1 for exactly one cycle; busy ← 0.
- D, borrow_out and V do not change during RUN. They show the previous result until the final edge.
- start while busy=1 is ignored. It is neither queued nor an error.
- Inputs a, b and borrow_in may change freely after the accepting edge.

## Timing
- Reset values: busy=0, done=0, D=0, borrow_out=0, V=0, state IDLE, held borrow 0, k=0.
- Reset asserted mid-operation aborts immediately. The partial result is discarded, no done pulse is produced, and outputs return to reset values.
- Latency: for start accepted at edge E0, busy=1 from E0 to E(NSLICE). At E(NSLICE), done=1, busy=0 and D is valid. For WIDTH=32 this is 4 cycles.
- Throughput: one operation per NSLICE cycles. start=1 in the cycle where done=1 (busy=0) is accepted, so back-to-back operations have no gap cycle. done still falls on the next edge.
- WIDTH=8: a single RUN cycle. done follows the accepting edge by one edge.

## Configuration
- OVERFLOW_FLAG_EN defined:
  - port V exists.
  - at completion, V ← (a[W−1] ^ b[W−1]) & (a[W−1] ^ D[W−1]), using the latched operands and the new D.
  - V holds until the next completion; reset value 0.
- OVERFLOW_FLAG_EN undefined: port V and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=32, a=0x00000005, b=0x00000003, borrow_in=0, start pulse → busy for 4 cycles, done pulse; D=0x00000002, borrow_out=0.
- a=0x00000000, b=0x00000001, borrow_in=0 → D=0xFFFFFFFF, borrow_out=1. With OVERFLOW_FLAG_EN, V=0.
- a=0x00000100, b=0x00000000, borrow_in=1 (cross-slice borrow) → D=0x000000FF, borrow_out=0.
- With OVERFLOW_FLAG_EN: a=0x80000000, b=0x00000001, borrow_in=0 → D=0x7FFFFFFF, borrow_out=0, V=1.
- Handshake:
  - start re-pulsed with new operands on cycle 2 of RUN → ignored; the first result is delivered unchanged.
  - start held high on the done cycle → second operation accepted; its done arrives exactly 4 edges later.
- rst_n pulsed low on cycle 2 of RUN → busy=0, done never pulses, D=0 and borrow_out=0 immediately. The next start completes normally.

Source files
------------

// File: rtl/borrow_look_ahead_subtractor.sv
// Multi-cycle subtractor: one 8-bit borrow-look-ahead slice per clock.
// Optional signed overflow flag V when OVERFLOW_FLAG_EN is defined.
module borrow_look_ahead_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             V
`endif
);

    localparam int NSLICE = WIDTH / 8;
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, part_q, part_d;
    logic [WIDTH+7:0] cat;
    logic             brw_q;
    logic [KW-1:0]    k_q;
    logic             last;
    logic [7:0]       x, y, g, p, d;
    logic [8:0]       c;

`ifdef OVERFLOW_FLAG_EN
    logic a_msb, b_msb;
`endif

    // Borrow into bit n as a flat sum of products of g, p and the held borrow.
    function automatic logic la(input int n, input logic [7:0] gg,
                                input logic [7:0] pp, input logic c0);
        logic r, t;
        r = c0;
        for (int m = 0; m < n; m++) r = r & pp[m];
        for (int j = 0; j < n; j++) begin
            t = gg[j];
            for (int m = j + 1; m < n; m++) t = t & pp[m];
            r = r | t;
        end
        return r;
    endfunction

    assign busy = (state_q == RUN);
    assign last = (k_q == KW'(NSLICE - 1));

    // Slice datapath: look-ahead borrows and difference of the low byte.
    always_comb begin
        x    = a_q[7:0];
        y    = b_q[7:0];
        g    = ~x & y;
        p    = ~(x ^ y);
        c    = '0;
        c[0] = brw_q;
        for (int i = 1; i <= 8; i++) c[i] = la(i, g, p, brw_q);
        d      = x ^ y ^ c[7:0];
        cat    = {d, part_q};
        part_d = cat[WIDTH+7:8];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice stepping and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            part_q     <= '0;
            brw_q      <= 1'b0;
            k_q        <= '0;
            done       <= 1'b0;
            D          <= '0;
            borrow_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            V          <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    a_q    <= a;
                    b_q    <= b;
                    brw_q  <= borrow_in;
                    part_q <= '0;
                    k_q    <= '0;
`ifdef OVERFLOW_FLAG_EN
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
`endif
                end
            end else begin
                a_q    <= a_q >> 8;
                b_q    <= b_q >> 8;
                part_q <= part_d;
                brw_q  <= c[8];
                k_q    <= k_q + 1'b1;
                if (last) begin
                    k_q        <= '0;
                    D          <= part_d;
                    borrow_out <= c[8];
                    done       <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
                    V <= (a_msb ^ b_msb) & (a_msb ^ part_d[WIDTH-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_borrow_look_ahead_subtractor.sv
// Bench for borrow_look_ahead_subtractor: arithmetic reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_borrow_look_ahead_subtractor;

    localparam int WIDTH = 32;
    localparam int NSLICE = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             borrow_in = 1'b0;
    logic             busy, done, borrow_out;
    logic [WIDTH-1:0] D;
`ifdef OVERFLOW_FLAG_EN
    logic             V;
`endif

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    borrow_look_ahead_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .borrow_in(borrow_in),
        .busy(busy),
        .done(done),
        .D(D),
        .borrow_out(borrow_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .V(V)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: whole-word arithmetic, NSLICE-cycle latency.
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_D = '0;
    logic             m_bo = 1'b0;
    logic             m_V = 1'b0;
    logic [WIDTH-1:0] p_D = '0;
    logic             p_bo = 1'b0;
    logic             p_V = 1'b0;
    int               m_cnt = 0;

    function automatic logic [WIDTH:0] udiff(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic bi);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    endfunction

    function automatic logic sovf(input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y,
                                  input logic bi);
        logic signed [WIDTH+1:0] r;
        r = $signed({{2{x[WIDTH-1]}}, x}) - $signed({{2{y[WIDTH-1]}}, y})
            - $signed({{(WIDTH+1){1'b0}}, bi});
        return (r[WIDTH+1:WIDTH-1] != 3'b000) && (r[WIDTH+1:WIDTH-1] != 3'b111);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_D    <= '0;
            m_bo   <= 1'b0;
            m_V    <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_D    <= p_D;
                    m_bo   <= p_bo;
                    m_V    <= p_V;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= NSLICE;
                {p_bo, p_D} <= udiff(a, b, borrow_in);
                p_V    <= sovf(a, b, borrow_in);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_busy", 64'(busy), 64'(m_busy));
                chk("m_done", 64'(done), 64'(m_done));
                chk("m_D", 64'(D), 64'(m_D));
                chk("m_borrow", 64'(borrow_out), 64'(m_bo));
`ifdef OVERFLOW_FLAG_EN
                chk("m_V", 64'(V), 64'(m_V));
`endif
            end
        end
    end

    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic bi);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        borrow_in = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        borrow_in = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: got no done expected done within 20 cycles", name);
        end
    endtask

    task automatic op(input string name, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, input logic bi,
                      input logic [WIDTH-1:0] ed, input logic eb);
        launch(x, y, bi);
        wait_done(name);
        chk({name, "_D"}, 64'(D), 64'(ed));
        chk({name, "_bo"}, 64'(borrow_out), 64'(eb));
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_D", 64'(D), 64'd0);
        chk("rst_bo", 64'(borrow_out), 64'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        op("sub5_3", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0);
        op("sub0_1", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1);
`ifdef OVERFLOW_FLAG_EN
        chk("sub0_1_V", 64'(V), 64'd0);
`endif
        op("xslice", 32'h100, 32'h0, 1'b1, 32'hFF, 1'b0);
        op("ovf", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0);
`ifdef OVERFLOW_FLAG_EN
        chk("ovf_V", 64'(V), 64'd1);
`endif
        op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        op("wide", 32'h0001_0000, 32'h1, 1'b0, 32'h0000_FFFF, 1'b0);
        op("equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0);

        // start during RUN is ignored
        launch(32'h10, 32'h1, 1'b0);
        @(posedge clk);
        #1;
        a = 32'hFFFF_0000;
        b = 32'h0000_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore");
        chk("ignore_D", 64'(D), 64'h0F);
        chk("ignore_bo", 64'(borrow_out), 64'd0);
        repeat (2) @(negedge clk);
        chk("ignore_idle", 64'(busy), 64'd0);

        // back-to-back: start on the done cycle
        launch(32'h20, 32'h10, 1'b0);
        wait_done("b2b_first");
        chk("b2b_first_D", 64'(D), 64'h10);
        a = 32'h7;
        b = 32'h9;
        borrow_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
        chk("b2b_lat", 64'(n), 64'd4);
        chk("b2b_D", 64'(D), 64'hFFFF_FFFE);
        chk("b2b_bo", 64'(borrow_out), 64'd1);

        // reset mid-operation
        launch(32'h1234, 32'h34, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_D", 64'(D), 64'd0);
        chk("abort_bo", 64'(borrow_out), 64'd1 - 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_nodone", 64'(done), 64'd0);
        op("after_rst", 32'h1234, 32'h34, 1'b0, 32'h1200, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
